mbist_march_ctrl: RTL and testbench

- March C- sequencer for the two-bank byte-wide `memory` model.
- Walks every (bank, row, byte-column) address and drives the memory's ce/we/row/col/bank/data inputs.
- Compares read data against the expected background one cycle after each read and reports mismatches through a valid/ready fault port.
- Sits between the BIST top level (start/done/pass) and the memory array; it is the only master of the memory port during test.

---
 rtl/mbist_pkg.sv | 50 +++++
 rtl/mbist_march_ctrl_if.sv | 33 +++
 rtl/mbist_addr_gen.sv | 82 ++++++++
 rtl/mbist_march_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_mbist_march_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mbist_pkg.sv
// Shared types and constants for the March C- memory BIST sequencer.
// Element op tables live here so the controller just indexes them.
package mbist_pkg;

  typedef enum logic [2:0] {M0, M1, M2, M3, M4, M5} elem_e;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  localparam logic [7:0] BG0   = 8'h00;
  localparam logic [7:0] BG1   = 8'hFF;
  localparam logic [1:0] BANK0 = 2'b01;
  localparam logic [1:0] BANK1 = 2'b10;

  function automatic logic elem_two_op(elem_e e);
    return (e inside {M1, M2, M3, M4});
  endfunction

  function automatic logic elem_down(elem_e e);
    return (e inside {M3, M4});
  endfunction

  // op 0 is the read of a read/write pair
  function automatic logic op_is_write(elem_e e, logic op);
    case (e)
      M0:      return 1'b1;
      M5:      return 1'b0;
      default: return op;
    endcase
  endfunction

  function automatic logic [7:0] op_value(elem_e e, logic op);
    case (e)
      M1, M3:  return op ? BG1 : BG0;
      M2, M4:  return op ? BG0 : BG1;
      default: return BG0;
    endcase
  endfunction

  function automatic elem_e elem_next(elem_e e);
    case (e)
      M0:      return M1;
      M1:      return M2;
      M2:      return M3;
      M3:      return M4;
      M4:      return M5;
      default: return M0;
    endcase
  endfunction

endpackage

// File: rtl/mbist_march_ctrl_if.sv
// Memory command/read-data port plus the fault record valid/ready port.
// master = BIST controller side, slave = memory / fault consumer side.
interface mbist_march_ctrl_if;
  logic       mem_ce;
  logic       mem_we;
  logic [9:0] mem_row;
  logic [9:0] mem_col;
  logic [1:0] mem_bank;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  logic       fault_valid;
  logic       fault_ready;
  logic [9:0] fault_row;
  logic [9:0] fault_col;
  logic [1:0] fault_bank;
  logic [7:0] fault_data;
  logic [7:0] fault_expect;

  modport master (
    output mem_ce, mem_we, mem_row, mem_col, mem_bank, mem_wdata,
    input  mem_rdata,
    output fault_valid, fault_row, fault_col, fault_bank, fault_data, fault_expect,
    input  fault_ready
  );

  modport slave (
    input  mem_ce, mem_we, mem_row, mem_col, mem_bank, mem_wdata,
    output mem_rdata,
    input  fault_valid, fault_row, fault_col, fault_bank, fault_data, fault_expect,
    output fault_ready
  );
endinterface

// File: rtl/mbist_addr_gen.sv
// Up/down walker over the linear address {bank, row, col/8}, col/8 innermost.
// Direction is latched on load so the last flag never depends on the next element.
module mbist_addr_gen #(
  parameter int unsigned ROWS = 1024,
  parameter int unsigned COLS = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic       i_step,
  input  logic       i_down,
  output logic [9:0] o_row,
  output logic [9:0] o_col,
  output logic       o_bank,
  output logic       o_last
);

  localparam logic [9:0] ROW_MAX = 10'(ROWS - 1);
  localparam logic [6:0] CB_MAX  = 7'(COLS / 8 - 1);

  logic [9:0] r_row;
  logic [6:0] r_colb;
  logic       r_bank;
  logic       r_down;
  logic       w_at_min;
  logic       w_at_max;

  assign w_at_min = !r_bank && (r_row == '0) && (r_colb == '0);
  assign w_at_max = r_bank && (r_row == ROW_MAX) && (r_colb == CB_MAX);

  assign o_row  = r_row;
  assign o_col  = {r_colb, 3'b000};
  assign o_bank = r_bank;
  assign o_last = r_down ? w_at_min : w_at_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row  <= '0;
      r_colb <= '0;
      r_bank <= 1'b0;
      r_down <= 1'b0;
    end else if (i_load) begin
      r_down <= i_down;
      if (i_down) begin
        r_bank <= 1'b1;
        r_row  <= ROW_MAX;
        r_colb <= CB_MAX;
      end else begin
        r_bank <= 1'b0;
        r_row  <= '0;
        r_colb <= '0;
      end
    end else if (i_step) begin
      if (r_down) begin
        if (r_colb == '0) begin
          r_colb <= CB_MAX;
          if (r_row == '0) begin
            r_row  <= ROW_MAX;
            r_bank <= ~r_bank;
          end else begin
            r_row <= r_row - 1'b1;
          end
        end else begin
          r_colb <= r_colb - 1'b1;
        end
      end else begin
        if (r_colb == CB_MAX) begin
          r_colb <= '0;
          if (r_row == ROW_MAX) begin
            r_row  <= '0;
            r_bank <= ~r_bank;
          end else begin
            r_row <= r_row + 1'b1;
          end
        end else begin
          r_colb <= r_colb + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- sequencer: issues one memory op per cycle, compares read data one
// cycle later and stalls issue while a fault record is being handed off.
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int unsigned ROWS  = 1024,
  parameter int unsigned COLS  = 1024,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [CNT_W-1:0] o_fault_cnt,
  mbist_march_ctrl_if.master bus
);

  state_e           r_state;
  elem_e            r_elem;
  logic             r_op;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_fault_cnt;

  logic             r_cmp_vld;
  logic [7:0]       r_cmp_exp;
  logic [9:0]       r_cmp_row;
  logic [9:0]       r_cmp_col;
  logic [1:0]       r_cmp_bank;

  logic             r_fault_valid;
  logic [9:0]       r_fault_row;
  logic [9:0]       r_fault_col;
  logic [1:0]       r_fault_bank;
  logic [7:0]       r_fault_data;
  logic [7:0]       r_fault_expect;

  logic [9:0]       w_ag_row;
  logic [9:0]       w_ag_col;
  logic             w_ag_bank;
  logic             w_ag_last;
  logic             w_ag_load;
  logic             w_ag_step;
  logic             w_ag_down;
  logic [1:0]       w_bank_oh;
  logic             w_start_acc;
  logic             w_mismatch;
  logic             w_issue_en;
  logic             w_issue;
  logic             w_is_write;
  logic [7:0]       w_op_val;
  logic             w_elem_end;

  assign w_start_acc = i_start && (r_state == StIdle || r_state == StDone);
  assign w_mismatch  = r_cmp_vld && (bus.mem_rdata != r_cmp_exp);
  assign w_issue_en  = !w_mismatch && !(r_fault_valid && !bus.fault_ready);
  assign w_issue     = (r_state == StRun) && w_issue_en;
  assign w_is_write  = op_is_write(r_elem, r_op);
  assign w_op_val    = op_value(r_elem, r_op);
  assign w_bank_oh   = w_ag_bank ? BANK1 : BANK0;

  // Last op at the current address: the index moves or the element changes.
  assign w_elem_end = w_issue && (!elem_two_op(r_elem) || r_op);
  assign w_ag_step  = w_elem_end && !w_ag_last;
  assign w_ag_load  = w_start_acc || (w_elem_end && w_ag_last && r_elem != M5);
  assign w_ag_down  = w_start_acc ? 1'b0 : elem_down(elem_next(r_elem));

  mbist_addr_gen #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_addr_gen (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_ag_load),
    .i_step (w_ag_step),
    .i_down (w_ag_down),
    .o_row  (w_ag_row),
    .o_col  (w_ag_col),
    .o_bank (w_ag_bank),
    .o_last (w_ag_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= StIdle;
      r_elem         <= M0;
      r_op           <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_fault_cnt    <= '0;
      r_cmp_vld      <= 1'b0;
      r_cmp_exp      <= '0;
      r_cmp_row      <= '0;
      r_cmp_col      <= '0;
      r_cmp_bank     <= '0;
      r_fault_valid  <= 1'b0;
      r_fault_row    <= '0;
      r_fault_col    <= '0;
      r_fault_bank   <= '0;
      r_fault_data   <= '0;
      r_fault_expect <= '0;
    end else begin
      r_cmp_vld <= w_issue && !w_is_write;
      if (w_issue) begin
        r_cmp_exp  <= w_op_val;
        r_cmp_row  <= w_ag_row;
        r_cmp_col  <= w_ag_col;
        r_cmp_bank <= w_bank_oh;
      end

      if (w_mismatch) begin
        r_fault_valid  <= 1'b1;
        r_fault_row    <= r_cmp_row;
        r_fault_col    <= r_cmp_col;
        r_fault_bank   <= r_cmp_bank;
        r_fault_data   <= bus.mem_rdata;
        r_fault_expect <= r_cmp_exp;
        if (r_fault_cnt != '1) r_fault_cnt <= r_fault_cnt + 1'b1;
      end else if (r_fault_valid && bus.fault_ready) begin
        r_fault_valid <= 1'b0;
      end

      unique case (r_state)
        StIdle, StDone: begin
          if (i_start) begin
            r_state     <= StRun;
            r_elem      <= M0;
            r_op        <= 1'b0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_fault_cnt <= '0;
          end
        end
        StRun: begin
          if (w_issue) begin
            if (!w_elem_end) begin
              r_op <= 1'b1;
            end else begin
              r_op <= 1'b0;
              if (w_ag_last) begin
                if (r_elem == M5) r_state <= StDrain;
                else r_elem <= elem_next(r_elem);
              end
            end
          end
        end
        StDrain: begin
          // Final compare happens this cycle; a fault it raises must be handed off first.
          if (!w_mismatch && (!r_fault_valid || bus.fault_ready)) begin
            r_state <= StDone;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.mem_ce       = w_issue;
  assign bus.mem_we       = w_issue && w_is_write;
  assign bus.mem_row      = w_issue ? w_ag_row : '0;
  assign bus.mem_col      = w_issue ? w_ag_col : '0;
  assign bus.mem_bank     = w_issue ? w_bank_oh : '0;
  assign bus.mem_wdata    = w_issue ? w_op_val : '0;

  assign bus.fault_valid  = r_fault_valid;
  assign bus.fault_row    = r_fault_row;
  assign bus.fault_col    = r_fault_col;
  assign bus.fault_bank   = r_fault_bank;
  assign bus.fault_data   = r_fault_data;
  assign bus.fault_expect = r_fault_expect;

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_pass      = r_done && (r_fault_cnt == '0);
  assign o_fault_cnt = r_fault_cnt;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: a byte memory with an optional stuck-at-1 bit,
// an op-list model of March C- and a per-cycle checker on the memory/fault ports.
module tb_mbist_march_ctrl;

  localparam int ROWS      = 4;
  localparam int COLS      = 16;
  localparam int CNT_W     = 8;
  localparam int CB        = COLS / 8;
  localparam int N         = 2 * ROWS * CB;
  localparam int NOPS      = 10 * N;
  localparam int STUCK_IDX = 0 * ROWS * CB + 2 * CB + 1;  // bank0, row2, byte col 8

  typedef struct packed {
    logic       we;
    logic [9:0] row;
    logic [9:0] col;
    logic [1:0] bank;
    logic [7:0] data;
  } op_t;

  typedef struct packed {
    logic [9:0] row;
    logic [9:0] col;
    logic [1:0] bank;
    logic [7:0] data;
    logic [7:0] expct;
  } flt_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] fault_cnt;

  mbist_march_ctrl_if bus ();

  mbist_march_ctrl #(
    .ROWS  (ROWS),
    .COLS  (COLS),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (start),
    .o_busy      (busy),
    .o_done      (done),
    .o_pass      (pass),
    .o_fault_cnt (fault_cnt),
    .bus         (bus)
  );

  initial forever #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  int   n_ops = 0;
  int   k_flt = 0;
  int   busy_cycles = 0;
  bit   stuck = 0;
  bit   stall_mode = 0;
  int   stall_cnt = 0;
  op_t  exp_ops[$];
  int   exp_idx[$];
  flt_t exp_flts[$];
  logic [7:0] mem [0:N-1];

  // March C- as a table: ops per element, direction, and (write?, value) per op.
  int         nops [6]     = '{1, 2, 2, 2, 2, 1};
  bit         dn   [6]     = '{0, 0, 0, 1, 1, 0};
  bit         w_tab[6][2]  = '{'{1, 0}, '{0, 1}, '{0, 1}, '{0, 1}, '{0, 1}, '{0, 0}};
  logic [7:0] v_tab[6][2]  = '{'{8'h00, 8'h00}, '{8'h00, 8'hFF}, '{8'hFF, 8'h00},
                               '{8'h00, 8'hFF}, '{8'hFF, 8'h00}, '{8'h00, 8'h00}};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 'h%0h, want 'h%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic build_ops();
    op_t o;
    int  idx;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < N; i++) begin
        idx = dn[e] ? (N - 1 - i) : i;
        for (int k = 0; k < nops[e]; k++) begin
          o.we   = w_tab[e][k];
          o.row  = 10'((idx / CB) % ROWS);
          o.col  = 10'((idx % CB) * 8);
          o.bank = (idx / (ROWS * CB)) != 0 ? 2'b10 : 2'b01;
          o.data = v_tab[e][k];
          exp_ops.push_back(o);
          exp_idx.push_back(idx);
        end
      end
    end
  endtask

  // Replays the op list against an ideal memory with the optional stuck bit.
  task automatic build_faults(input bit stk);
    logic [7:0] shadow [0:N-1];
    logic [7:0] got;
    flt_t       f;
    exp_flts.delete();
    for (int i = 0; i < N; i++) shadow[i] = 8'h00;
    for (int i = 0; i < exp_ops.size(); i++) begin
      if (exp_ops[i].we) begin
        shadow[exp_idx[i]] = exp_ops[i].data;
      end else begin
        got = shadow[exp_idx[i]] | ((stk && exp_idx[i] == STUCK_IDX) ? 8'h80 : 8'h00);
        if (got != exp_ops[i].data) begin
          f.row   = exp_ops[i].row;
          f.col   = exp_ops[i].col;
          f.bank  = exp_ops[i].bank;
          f.data  = got;
          f.expct = exp_ops[i].data;
          exp_flts.push_back(f);
        end
      end
    end
  endtask

  // Memory: read data registered, valid the cycle after the read issue.
  always @(posedge clk) begin
    int idx;
    if (bus.mem_ce) begin
      idx = (bus.mem_bank[1] ? ROWS * CB : 0) + int'(bus.mem_row) * CB + int'(bus.mem_col) / 8;
      if (bus.mem_we) mem[idx] <= bus.mem_wdata;
      else bus.mem_rdata <= mem[idx] | ((stuck && idx == STUCK_IDX) ? 8'h80 : 8'h00);
    end
  end

  // Fault consumer: either always ready, or holds ready low for 5 cycles of fault_valid.
  initial begin
    bus.fault_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (!stall_mode) begin
        bus.fault_ready = 1'b1;
        stall_cnt = 0;
      end else begin
        if (bus.fault_valid) stall_cnt++;
        else stall_cnt = 0;
        bus.fault_ready = (stall_cnt > 5);
      end
    end
  end

  logic       prev_stall = 1'b0;
  logic [63:0] prev_f = '0;

  always @(negedge clk) begin
    op_t         e;
    op_t         a;
    logic [63:0] cur_f;
    if (!rst) begin
      if (busy) busy_cycles++;
      if (bus.mem_ce) begin
        if (n_ops < NOPS) begin
          e = exp_ops[n_ops];
          a.we   = bus.mem_we;
          a.row  = bus.mem_row;
          a.col  = bus.mem_col;
          a.bank = bus.mem_bank;
          a.data = bus.mem_we ? bus.mem_wdata : 8'h00;
          if (!e.we) e.data = 8'h00;
          chk($sformatf("op[%0d]", n_ops), 64'(a), 64'(e));
        end else begin
          tests++;
          fails++;
          $display("FAIL extra_op: got op #%0d, want at most %0d ops", n_ops + 1, NOPS);
        end
        n_ops++;
      end
      cur_f = {26'd0, bus.fault_row, bus.fault_col, bus.fault_bank,
               bus.fault_data, bus.fault_expect};
      if (bus.fault_valid && !bus.fault_ready) chk("ce_low_in_stall", 64'(bus.mem_ce), 64'd0);
      if (prev_stall && bus.fault_valid) chk("fault_stable", cur_f, prev_f);
      if (bus.fault_valid && bus.fault_ready) begin
        if (k_flt < exp_flts.size()) begin
          chk($sformatf("fault_rec[%0d]", k_flt), cur_f, {26'd0, exp_flts[k_flt]});
        end else begin
          tests++;
          fails++;
          $display("FAIL extra_fault: got record #%0d, want %0d", k_flt + 1, exp_flts.size());
        end
        k_flt++;
      end
      prev_stall = bus.fault_valid && !bus.fault_ready;
      prev_f     = cur_f;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic check_all_zero(input string nm);
    chk({nm, "_ctl"}, {busy, done, pass, fault_cnt}, '0);
    chk({nm, "_mem"}, {bus.mem_ce, bus.mem_we, bus.mem_row, bus.mem_col, bus.mem_bank,
                       bus.mem_wdata}, '0);
    chk({nm, "_flt"}, {bus.fault_valid, bus.fault_row, bus.fault_col, bus.fault_bank,
                       bus.fault_data, bus.fault_expect}, '0);
  endtask

  task automatic run_test(input string nm, input bit stk, input bit stl, input bit busy_pulse);
    int cyc;
    int nflt;
    stuck      = stk;
    stall_mode = stl;
    build_faults(stk);
    nflt        = exp_flts.size();
    n_ops       = 0;
    k_flt       = 0;
    busy_cycles = 0;
    @(posedge clk);
    #1 start = 1'b1;
    @(negedge clk);
    chk({nm, "_busy_before"}, 64'(busy), 64'd0);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk({nm, "_busy_rise"}, 64'(busy), 64'd1);
    chk({nm, "_cleared"}, {done, fault_cnt}, '0);
    cyc = 0;
    while (!done && cyc < 3000) begin
      @(posedge clk);
      #1 start = busy_pulse && (cyc == 20);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({nm, "_done_in_time"}, 64'(done), 64'd1);
    chk({nm, "_op_count"}, 64'(n_ops), 64'(NOPS));
    chk({nm, "_busy_cycles"}, 64'(busy_cycles), 64'(NOPS + 1 + nflt * (1 + (stl ? 5 : 0))));
    chk({nm, "_fault_recs"}, 64'(k_flt), 64'(nflt));
    chk({nm, "_fault_cnt"}, 64'(fault_cnt), 64'(nflt));
    chk({nm, "_pass"}, 64'(pass), 64'(nflt == 0));
    chk({nm, "_busy_low"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int cyc;
    rst   = 1'b1;
    start = 1'b0;
    build_ops();

    // Pin the op-list model against hand-derived entries.
    chk("model_size", 64'(exp_ops.size()), 64'd160);
    chk("model_op0", 64'(exp_ops[0]), {33'd0, 1'b1, 10'd0, 10'd0, 2'b01, 8'h00});
    chk("model_m1_rd", 64'(exp_ops[18]), {33'd0, 1'b0, 10'd0, 10'd8, 2'b01, 8'h00});
    chk("model_m1_wr", 64'(exp_ops[19]), {33'd0, 1'b1, 10'd0, 10'd8, 2'b01, 8'hFF});
    chk("model_m3_first", 64'(exp_ops[80]), {33'd0, 1'b0, 10'd3, 10'd8, 2'b10, 8'h00});
    build_faults(1'b1);
    chk("model_stuck_cnt", 64'(exp_flts.size()), 64'd3);
    chk("model_stuck_rec0", 64'(exp_flts[0]), {26'd0, 10'd2, 10'd8, 2'b01, 8'h80, 8'h00});

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    run_test("clean", 1'b0, 1'b0, 1'b0);
    run_test("stuck", 1'b1, 1'b0, 1'b0);
    run_test("stall", 1'b1, 1'b1, 1'b0);
    run_test("restart", 1'b0, 1'b0, 1'b0);

    // Abort mid-M2 with a one-cycle reset.
    stuck      = 1'b0;
    stall_mode = 1'b0;
    n_ops      = 0;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    while (n_ops < 53 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort_reached_m2", 64'(n_ops >= 53), 64'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_all_zero("abort_reset");
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_no_done", {busy, done}, 64'd0);
    run_test("rerun", 1'b0, 1'b0, 1'b0);

    run_test("busy_pulse", 1'b0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
